// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: op field width and
// extension-mode encodings.
package imm_ext_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEXT     = 3'b000,
    OP_ZEXT     = 3'b001,
    OP_HIGH     = 3'b010,
    OP_SEXT_SHL = 3'b011,
    OP_ZEXT_SHL = 3'b100
  } op_e;

  // Encodings above OP_ZEXT_SHL are reserved.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_ZEXT_SHL);
  endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// Two-entry skid FIFO with a valid/ready handshake on both sides. Ready and
// valid are registered, so in_ready never depends combinationally on out_ready.
module imm_ext_skid #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push_valid,
  output logic         o_push_ready,
  input  logic [W-1:0] i_push_data,
  output logic         o_pop_valid,
  input  logic         i_pop_ready,
  output logic [W-1:0] o_pop_data
);

  logic [1:0]   r_count;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_nxt;

  assign w_push = i_push_valid & r_in_ready;
  assign w_pop  = r_out_valid & i_pop_ready;

  // Occupancy after this edge's transfers.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage update: r_head is always the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= i_push_data;
          end else begin
            r_tail <= i_push_data;
          end
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_push_ready = r_in_ready;
  assign o_pop_valid  = r_out_valid;
  assign o_pop_data   = r_head;

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a 2-entry skid buffer (1-cycle latency).
// Define IMM_EXT_ILLEGAL_FLAG_EN to zero illegal ops and expose a sticky err port.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHAMT  = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef IMM_EXT_ILLEGAL_FLAG_EN
  ,
  output logic              err
`endif
);

  generate
    if ((DATA_W < IMM_W + SHAMT) || (DATA_W <= IMM_W)) begin : g_param_check
      $error("imm_ext_pipe: DATA_W must exceed IMM_W and hold IMM_W+SHAMT bits");
    end
  endgenerate

  logic [DATA_W-1:0]       w_sext;
  logic [DATA_W-1:0]       w_zext;
  logic [DATA_W-1:0]       w_high;
  logic [DATA_W-1:0]       w_ext;
  logic [DATA_W+TAG_W-1:0] w_pop_data;

  assign w_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
  assign w_high = {in_imm, {(DATA_W-IMM_W){1'b0}}};

  // Extension mode select; reserved ops depend on the illegal-flag build.
  always_comb begin
    w_ext = w_sext;
    case (in_op)
      OP_SEXT:     w_ext = w_sext;
      OP_ZEXT:     w_ext = w_zext;
      OP_HIGH:     w_ext = w_high;
      OP_SEXT_SHL: w_ext = w_sext << SHAMT;
      OP_ZEXT_SHL: w_ext = w_zext << SHAMT;
`ifdef IMM_EXT_ILLEGAL_FLAG_EN
      default:     w_ext = '0;
`else
      default:     w_ext = w_sext;
`endif
    endcase
  end

  imm_ext_skid #(
    .W (DATA_W + TAG_W)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_push_data  ({w_ext, in_tag}),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (w_pop_data)
  );

  assign out_data = w_pop_data[DATA_W+TAG_W-1:TAG_W];
  assign out_tag  = w_pop_data[TAG_W-1:0];

`ifdef IMM_EXT_ILLEGAL_FLAG_EN
  logic r_err;

  // Sticky flag, set on the edge that accepts a reserved op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (in_valid && in_ready && !op_is_legal(in_op)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`endif

endmodule
